// File: rtl/abr_prim_diff_decode_pkg.sv
// Shared types and constants for the multi-channel differential-pair decoder.
package abr_prim_diff_decode_pkg;

    typedef enum logic [1:0] {DdStd, DdSkew, DdSigint} abr_dd_state_e;

    localparam int unsigned SkewCntW = 3;

endpackage

// File: rtl/abr_prim_diff_decode_chan.sv
// One differential pair: optional resync, skew-tolerant decode FSM, level register,
// sticky signal-integrity flag and saturating episode counter.
module abr_prim_diff_decode_chan
    import abr_prim_diff_decode_pkg::*;
#(
    parameter bit          AsyncOn = 1'b1,
    parameter int unsigned MaxSkew = 1,
    parameter int unsigned CntW    = 8
) (
    input  logic            clk_i,
    input  logic            rst_b,
    input  logic            diff_pi,
    input  logic            diff_ni,
    input  logic            clr_i,
    output logic            level_o,
    output logic            rise_o,
    output logic            fall_o,
    output logic            sigint_o,
    output logic            sigint_sticky_o,
    output logic [CntW-1:0] sigint_cnt_o
);

    logic            pd, nd, pq_q, ok;
    logic            rise_raw, fall_raw, sigint_raw, level_raw;
    logic            level_q, level_d;
    logic            sigint_q, sticky_q, sticky_d, episode_start;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign ok = pd ^ nd;

    generate
        if (AsyncOn) begin : gen_async
            localparam logic [SkewCntW-1:0] MaxSkewC = SkewCntW'(MaxSkew);

            logic                nq_q, ep, en;
            logic [SkewCntW-1:0] skc_q, skc_d;
            abr_dd_state_e       state_q, state_d;

            abr_prim_flop_2sync #(
                .Width      (2),
                .ResetValue (2'b01)
            ) u_sync (
                .clk_i (clk_i),
                .rst_b (rst_b),
                .d_i   ({diff_pi, diff_ni}),
                .q_o   ({pd, nd})
            );

            assign ep = pd ^ pq_q;
            assign en = nd ^ nq_q;

            always_ff @(posedge clk_i or negedge rst_b) begin
                if (!rst_b) begin
                    nq_q    <= 1'b1;
                    skc_q   <= '0;
                    state_q <= DdStd;
                end else begin
                    nq_q    <= nd;
                    skc_q   <= skc_d;
                    state_q <= state_d;
                end
            end

            // A lone wire transition starts a skew window; the partner must follow
            // within MaxSkew cycles or the pair is flagged.
            always_comb begin
                state_d    = state_q;
                skc_d      = skc_q;
                level_d    = level_q;
                rise_raw   = 1'b0;
                fall_raw   = 1'b0;
                sigint_raw = 1'b0;
                unique case (state_q)
                    DdStd: begin
                        if (ok) begin
                            level_d = pd;
                            if (ep && en) begin
                                rise_raw = pd;
                                fall_raw = ~pd;
                            end
                        end else if (ep || en) begin
                            state_d = DdSkew;
                            skc_d   = SkewCntW'(1);
                        end else begin
                            state_d    = DdSigint;
                            sigint_raw = 1'b1;
                        end
                    end
                    DdSkew: begin
                        if (ok) begin
                            state_d  = DdStd;
                            level_d  = pd;
                            rise_raw = pd;
                            fall_raw = ~pd;
                        end else if (skc_q < MaxSkewC) begin
                            skc_d = skc_q + SkewCntW'(1);
                        end else begin
                            state_d    = DdSigint;
                            sigint_raw = 1'b1;
                        end
                    end
                    DdSigint: begin
                        if (ok) begin
                            state_d = DdStd;
                        end else begin
                            sigint_raw = 1'b1;
                        end
                    end
                    default: state_d = DdStd;
                endcase
            end

            assign level_raw = level_q;
        end else begin : gen_sync
            assign pd = diff_pi;
            assign nd = diff_ni;

            always_comb begin
                sigint_raw = ~ok;
                level_raw  = sigint_raw ? level_q : pd;
                rise_raw   = ~pq_q & pd & ok;
                fall_raw   = pq_q & ~pd & ok;
                level_d    = level_raw;
            end
        end
    endgenerate

    // Outputs are forced low while reset is held, even where they are combinational.
    assign level_o  = rst_b & level_raw;
    assign rise_o   = rst_b & rise_raw;
    assign fall_o   = rst_b & fall_raw;
    assign sigint_o = rst_b & sigint_raw;

    assign episode_start = sigint_o & ~sigint_q;
    assign sticky_d      = sigint_o | (sticky_q & ~clr_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = episode_start ? CntW'(1) : '0;
        end else if (episode_start && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            pq_q     <= 1'b0;
            level_q  <= 1'b0;
            sigint_q <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pq_q     <= pd;
            level_q  <= level_d;
            sigint_q <= sigint_o;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sigint_sticky_o = sticky_q;
    assign sigint_cnt_o    = cnt_q;

endmodule

// File: rtl/abr_prim_flop_2sync.sv
// Two-stage synchroniser bringing asynchronous wires into the clk_i domain.
module abr_prim_flop_2sync #(
    parameter int unsigned       Width      = 1,
    parameter logic [Width-1:0]  ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_b,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage1_q, stage2_q;

    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            stage1_q <= ResetValue;
            stage2_q <= ResetValue;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/abr_prim_diff_decode_mc.sv
// Multi-channel differential-pair decoder: NumChan independent channel decoders
// plus a combined signal-integrity indication.
module abr_prim_diff_decode_mc
    import abr_prim_diff_decode_pkg::*;
#(
    parameter int unsigned NumChan = 4,
    parameter bit          AsyncOn = 1'b1,
    parameter int unsigned MaxSkew = 1,
    parameter int unsigned CntW    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_b,
    input  logic [NumChan-1:0]      diff_pi,
    input  logic [NumChan-1:0]      diff_ni,
    input  logic                    clr_i,
    output logic [NumChan-1:0]      level_o,
    output logic [NumChan-1:0]      rise_o,
    output logic [NumChan-1:0]      fall_o,
    output logic [NumChan-1:0]      event_o,
    output logic [NumChan-1:0]      sigint_o,
    output logic                    sigint_any_o,
    output logic [NumChan-1:0]      sigint_sticky_o,
    output logic [NumChan*CntW-1:0] sigint_cnt_o
);

    for (genvar i = 0; i < NumChan; i++) begin : gen_chan
        abr_prim_diff_decode_chan #(
            .AsyncOn (AsyncOn),
            .MaxSkew (MaxSkew),
            .CntW    (CntW)
        ) u_chan (
            .clk_i           (clk_i),
            .rst_b           (rst_b),
            .diff_pi         (diff_pi[i]),
            .diff_ni         (diff_ni[i]),
            .clr_i           (clr_i),
            .level_o         (level_o[i]),
            .rise_o          (rise_o[i]),
            .fall_o          (fall_o[i]),
            .sigint_o        (sigint_o[i]),
            .sigint_sticky_o (sigint_sticky_o[i]),
            .sigint_cnt_o    (sigint_cnt_o[i*CntW +: CntW])
        );
    end

    assign event_o      = rise_o | fall_o;
    assign sigint_any_o = |sigint_o;

endmodule

// File: tb/tb_abr_prim_diff_decode_mc.sv
// Bench for abr_prim_diff_decode_mc: async and sync-mode instances driven in parallel,
// checked every cycle against a run-length reference model plus directed scenarios.
module tb_abr_prim_diff_decode_mc;

    localparam int NumChan = 2;
    localparam int MaxSkew = 2;
    localparam int CntW    = 2;
    localparam int MaxCnt  = (1 << CntW) - 1;

    logic                    clk = 1'b0;
    logic                    rst_b;
    logic [NumChan-1:0]      diffP, diffN;
    logic                    clr;
    logic                    checkEn;

    logic [NumChan-1:0]      aLevel, aRise, aFall, aEvent, aSig, aSticky;
    logic                    aAny;
    logic [NumChan*CntW-1:0] aCnt;
    logic [NumChan-1:0]      sLevel, sRise, sFall, sEvent, sSig, sSticky;
    logic                    sAny;
    logic [NumChan*CntW-1:0] sCnt;

    int checkCount = 0;
    int passCount  = 0;

    // Model state: wire delay line for the async instance, then decode history.
    bit s1P[NumChan], s1N[NumChan], dP[NumChan], dN[NumChan], qP[NumChan], qN[NumChan];
    int run[NumChan];
    bit levA[NumChan], sigPrevA[NumChan], stickyA[NumChan];
    int cntA[NumChan];
    bit sP[NumChan], levS[NumChan], sigPrevS[NumChan], stickyS[NumChan];
    int cntS[NumChan];

    always #5 clk = ~clk;

    abr_prim_diff_decode_mc #(
        .NumChan (NumChan), .AsyncOn (1'b1), .MaxSkew (MaxSkew), .CntW (CntW)
    ) dut (
        .clk_i (clk), .rst_b (rst_b), .diff_pi (diffP), .diff_ni (diffN), .clr_i (clr),
        .level_o (aLevel), .rise_o (aRise), .fall_o (aFall), .event_o (aEvent),
        .sigint_o (aSig), .sigint_any_o (aAny), .sigint_sticky_o (aSticky),
        .sigint_cnt_o (aCnt)
    );

    abr_prim_diff_decode_mc #(
        .NumChan (NumChan), .AsyncOn (1'b0), .MaxSkew (MaxSkew), .CntW (CntW)
    ) dutSync (
        .clk_i (clk), .rst_b (rst_b), .diff_pi (diffP), .diff_ni (diffN), .clr_i (clr),
        .level_o (sLevel), .rise_o (sRise), .fall_o (sFall), .event_o (sEvent),
        .sigint_o (sSig), .sigint_any_o (sAny), .sigint_sticky_o (sSticky),
        .sigint_cnt_o (sCnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NumChan-1:0] p, input logic [NumChan-1:0] n,
                                 input logic c);
        @(posedge clk);
        #1;
        diffP = p;
        diffN = n;
        clr   = c;
    endtask

    task automatic resetModel();
        for (int ch = 0; ch < NumChan; ch++) begin
            s1P[ch] = 1'b0; s1N[ch] = 1'b1;
            dP[ch]  = 1'b0; dN[ch]  = 1'b1;
            qP[ch]  = 1'b0; qN[ch]  = 1'b1;
            run[ch] = 0;
            levA[ch] = 1'b0; sigPrevA[ch] = 1'b0; stickyA[ch] = 1'b0; cntA[ch] = 0;
            sP[ch]   = 1'b0; levS[ch] = 1'b0; sigPrevS[ch] = 1'b0; stickyS[ch] = 1'b0;
            cntS[ch] = 0;
        end
    endtask

    task automatic episodeModel(input bit sig, input bit prevSig, input bit clrV,
                                input int cntIn, input bit stickyIn,
                                output int cntOut, output bit stickyOut);
        bit start;
        start = sig && !prevSig;
        if (clrV) cntOut = start ? 1 : 0;
        else if (start) cntOut = (cntIn < MaxCnt) ? cntIn + 1 : MaxCnt;
        else cntOut = cntIn;
        stickyOut = sig || (stickyIn && !clrV);
    endtask

    always @(posedge clk) begin
        if (rst_b) begin
            for (int ch = 0; ch < NumChan; ch++) begin
                qP[ch] = dP[ch];   qN[ch] = dN[ch];
                dP[ch] = s1P[ch];  dN[ch] = s1N[ch];
                s1P[ch] = diffP[ch]; s1N[ch] = diffN[ch];
            end
        end
    end

    always @(negedge clk) begin
        logic [NumChan-1:0]      eLevA, eRiseA, eFallA, eSigA, eStkA;
        logic [NumChan-1:0]      eLevS, eRiseS, eFallS, eSigS, eStkS;
        logic [NumChan*CntW-1:0] eCntA, eCntS;
        bit ok, p, n;
        if (checkEn) begin
            eLevA = '0; eRiseA = '0; eFallA = '0; eSigA = '0; eStkA = '0; eCntA = '0;
            eLevS = '0; eRiseS = '0; eFallS = '0; eSigS = '0; eStkS = '0; eCntS = '0;
            if (!rst_b) begin
                resetModel();
            end else begin
                for (int ch = 0; ch < NumChan; ch++) begin
                    // Async: run = consecutive mismatched cycles before this one.
                    ok = dP[ch] ^ dN[ch];
                    if (ok) begin
                        if ((run[ch] == 0 && dP[ch] != qP[ch]) ||
                            (run[ch] > 0 && run[ch] <= MaxSkew)) begin
                            eRiseA[ch] = dP[ch];
                            eFallA[ch] = !dP[ch];
                        end
                    end
                    eSigA[ch] = !ok && (run[ch] + 1 > MaxSkew);
                    eLevA[ch] = levA[ch];
                    eStkA[ch] = stickyA[ch];
                    eCntA[ch*CntW +: CntW] = CntW'(cntA[ch]);
                    if (ok && run[ch] <= MaxSkew) levA[ch] = dP[ch];
                    run[ch] = ok ? 0 : ((run[ch] < 50) ? run[ch] + 1 : run[ch]);
                    episodeModel(eSigA[ch], sigPrevA[ch], clr, cntA[ch], stickyA[ch],
                                 cntA[ch], stickyA[ch]);
                    sigPrevA[ch] = eSigA[ch];

                    // Sync: direct decode of the raw wires.
                    p  = diffP[ch];
                    n  = diffN[ch];
                    ok = p ^ n;
                    eSigS[ch]  = !ok;
                    eLevS[ch]  = eSigS[ch] ? levS[ch] : p;
                    eRiseS[ch] = !sP[ch] && p && ok;
                    eFallS[ch] = sP[ch] && !p && ok;
                    eStkS[ch]  = stickyS[ch];
                    eCntS[ch*CntW +: CntW] = CntW'(cntS[ch]);
                    levS[ch] = eLevS[ch];
                    sP[ch]   = p;
                    episodeModel(eSigS[ch], sigPrevS[ch], clr, cntS[ch], stickyS[ch],
                                 cntS[ch], stickyS[ch]);
                    sigPrevS[ch] = eSigS[ch];
                end
            end
            checkOutput("async_level",  32'(aLevel),  32'(eLevA));
            checkOutput("async_rise",   32'(aRise),   32'(eRiseA));
            checkOutput("async_fall",   32'(aFall),   32'(eFallA));
            checkOutput("async_event",  32'(aEvent),  32'(eRiseA | eFallA));
            checkOutput("async_sigint", 32'(aSig),    32'(eSigA));
            checkOutput("async_any",    32'(aAny),    32'(|eSigA));
            checkOutput("async_sticky", 32'(aSticky), 32'(eStkA));
            checkOutput("async_cnt",    32'(aCnt),    32'(eCntA));
            checkOutput("sync_level",   32'(sLevel),  32'(eLevS));
            checkOutput("sync_rise",    32'(sRise),   32'(eRiseS));
            checkOutput("sync_fall",    32'(sFall),   32'(eFallS));
            checkOutput("sync_event",   32'(sEvent),  32'(eRiseS | eFallS));
            checkOutput("sync_sigint",  32'(sSig),    32'(eSigS));
            checkOutput("sync_any",     32'(sAny),    32'(|eSigS));
            checkOutput("sync_sticky",  32'(sSticky), 32'(eStkS));
            checkOutput("sync_cnt",     32'(sCnt),    32'(eCntS));
        end
    end

    initial begin
        logic [NumChan-1:0] rp, rn;
        resetModel();
        rst_b = 1'b1; diffP = 2'b00; diffN = 2'b11; clr = 1'b0; checkEn = 1'b0;
        #1;
        rst_b   = 1'b0;
        checkEn = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_level",  32'(aLevel),  32'd0);
        checkOutput("reset_sticky", 32'(aSticky), 32'd0);
        checkOutput("reset_cnt",    32'(aCnt),    32'd0);
        @(posedge clk);
        #1 rst_b = 1'b1;
        repeat (4) applyStimulus(2'b00, 2'b11, 1'b0);

        // Clean simultaneous transition on ch0.
        applyStimulus(2'b01, 2'b10, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("t1_rise_early", 32'(aRise[0]), 32'd0);
        @(negedge clk);
        checkOutput("t1_rise", 32'(aRise[0]), 32'd1);
        @(negedge clk);
        checkOutput("t1_level", 32'(aLevel[0]), 32'd1);
        checkOutput("t1_sigint", 32'(aSig), 32'd0);

        // Skew within the window, then one cycle beyond it.
        repeat (5) applyStimulus(2'b00, 2'b11, 1'b0);
        repeat (2) applyStimulus(2'b01, 2'b11, 1'b0);
        repeat (6) applyStimulus(2'b01, 2'b10, 1'b0);
        checkOutput("t2_skew_sticky", 32'(aSticky[0]), 32'd0);
        checkOutput("t2_skew_level", 32'(aLevel[0]), 32'd1);
        repeat (5) applyStimulus(2'b00, 2'b11, 1'b0);
        repeat (3) applyStimulus(2'b01, 2'b11, 1'b0);
        repeat (6) applyStimulus(2'b01, 2'b10, 1'b0);
        checkOutput("t2_lag_sticky", 32'(aSticky[0]), 32'd1);
        checkOutput("t2_lag_cnt", 32'(aCnt[1:0]), 32'd1);

        // ch1 stuck at p=n=1 while ch0 stays at level 1.
        repeat (5) applyStimulus(2'b11, 2'b10, 1'b0);
        @(negedge clk);
        checkOutput("t3_sigint", 32'(aSig[1]), 32'd1);
        checkOutput("t3_any", 32'(aAny), 32'd1);
        repeat (6) applyStimulus(2'b01, 2'b10, 1'b0);
        checkOutput("t3_cnt", 32'(aCnt[3:2]), 32'd1);
        checkOutput("t3_levels", 32'(aLevel), 32'b01);

        // Counter saturation and clear.
        applyStimulus(2'b01, 2'b10, 1'b1);
        repeat (3) applyStimulus(2'b01, 2'b10, 1'b0);
        checkOutput("t4_clr_cnt", 32'(aCnt), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            repeat (5) applyStimulus(2'b00, 2'b10, 1'b0);
            repeat (5) applyStimulus(2'b01, 2'b10, 1'b0);
            checkOutput("t4_sat_cnt", 32'(aCnt[1:0]), 32'((k < MaxCnt) ? k : MaxCnt));
        end
        applyStimulus(2'b01, 2'b10, 1'b1);
        repeat (3) applyStimulus(2'b01, 2'b10, 1'b0);
        checkOutput("t4_clr_cnt2", 32'(aCnt[1:0]), 32'd0);
        checkOutput("t4_clr_sticky", 32'(aSticky[0]), 32'd0);

        // Clear landing on the first cycle of a new episode.
        repeat (5) applyStimulus(2'b00, 2'b10, 1'b0);
        repeat (5) applyStimulus(2'b01, 2'b10, 1'b0);
        repeat (4) applyStimulus(2'b00, 2'b10, 1'b0);
        applyStimulus(2'b00, 2'b10, 1'b1);
        applyStimulus(2'b00, 2'b10, 1'b0);
        @(negedge clk);
        checkOutput("t5_cnt", 32'(aCnt[1:0]), 32'd1);
        checkOutput("t5_sticky", 32'(aSticky[0]), 32'd1);
        repeat (5) applyStimulus(2'b01, 2'b10, 1'b0);

        // Sync-mode behaviour on ch1, then reset mid-episode.
        repeat (2) applyStimulus(2'b11, 2'b00, 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("t6_sigint", 32'(sSig[1]), 32'd1);
        checkOutput("t6_level_held", 32'(sLevel[1]), 32'd1);
        applyStimulus(2'b11, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("t6_rise", 32'(sRise[1]), 32'd1);
        applyStimulus(2'b01, 2'b00, 1'b0);
        #2 rst_b = 1'b0;
        #1;
        checkOutput("t6_rst_sigint", 32'(sSig), 32'd0);
        checkOutput("t6_rst_level", 32'(sLevel), 32'd0);
        checkOutput("t6_rst_sticky", 32'(sSticky), 32'd0);
        checkOutput("t6_rst_cnt", 32'(sCnt), 32'd0);
        checkOutput("t6_rst_async", 32'({aLevel, aSticky, aCnt}), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        diffP = 2'b00;
        diffN = 2'b11;

        // Random wire flips with occasional clears.
        for (int i = 0; i < 600; i++) begin
            rp = diffP;
            rn = diffN;
            for (int ch = 0; ch < NumChan; ch++) begin
                if ($urandom_range(5) == 0) rp[ch] = ~rp[ch];
                if ($urandom_range(5) == 0) rn[ch] = ~rn[ch];
            end
            applyStimulus(rp, rn, ($urandom_range(39) == 0));
        end
        repeat (3) applyStimulus(diffP, diffN, 1'b0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
